// File: rtl/pipe_hazard_ctrl.sv
// Hazard sequencer for a 5-stage pipeline: stall/flush/bubble/freeze, EX forwarding selects and wait timeout.
// Optional performance counters are enabled by defining HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int LOAD_STALL_CYC = 1,
  parameter int FLUSH_CYC      = 1,
  parameter int MEM_TIMEOUT    = 16,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_regadd,
  input  logic             mem_regwrite,
  input  logic [4:0]       mem_regadd,
  input  logic             wb_regwrite,
  input  logic [4:0]       wb_regadd,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_freeze,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
);

  localparam int REM_MAX = (LOAD_STALL_CYC > FLUSH_CYC) ? LOAD_STALL_CYC : FLUSH_CYC;
  localparam int REM_W   = $clog2(REM_MAX + 1);
  localparam int TMR_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [REM_W-1:0] LD_RELOAD = REM_W'(LOAD_STALL_CYC - 1);
  localparam logic [REM_W-1:0] FL_RELOAD = REM_W'(FLUSH_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_MAX   = TMR_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {RUN, LDUSE, FLUSH} state_t;

  state_t           state_reg, state_next;
  logic [REM_W-1:0] rem_reg, rem_next;
  logic [TMR_W-1:0] wtmr_reg, wtmr_next;
  logic             mem_wait, load_use;

  assign mem_wait = dmem_req && !dmem_ready;
  assign load_use = ex_memread && (ex_regadd != 5'd0) &&
                    ((ex_regadd == id_rs) || (id_uses_rt && (ex_regadd == id_rt)));

  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic m_wr,
                                         input logic [4:0] m_ad, input logic w_wr,
                                         input logic [4:0] w_ad);
    if (m_wr && (m_ad != 5'd0) && (m_ad == src))      return 2'b10;
    else if (w_wr && (w_ad != 5'd0) && (w_ad == src)) return 2'b01;
    else                                              return 2'b00;
  endfunction

  assign fwd_a = rst_n ? fwd_sel(ex_rs, mem_regwrite, mem_regadd, wb_regwrite, wb_regadd) : 2'b00;
  assign fwd_b = rst_n ? fwd_sel(ex_rt, mem_regwrite, mem_regadd, wb_regwrite, wb_regadd) : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RUN;
      rem_reg   <= '0;
      wtmr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      rem_reg   <= rem_next;
      wtmr_reg  <= wtmr_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    rem_next    = rem_reg;
    pc_write    = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    if (mem_wait) begin
      // Data memory stall freezes everything and masks all other events.
      pipe_freeze = 1'b1;
      ifid_hold   = 1'b1;
    end else begin
      case (state_reg)
        RUN: begin
          if (branch_taken) begin
            pc_write    = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            if (FLUSH_CYC > 1) begin
              state_next = FLUSH;
              rem_next   = FL_RELOAD;
            end
          end else if (load_use) begin
            ifid_hold   = 1'b1;
            idex_bubble = 1'b1;
            if (LOAD_STALL_CYC > 1) begin
              state_next = LDUSE;
              rem_next   = LD_RELOAD;
            end
          end else begin
            pc_write = 1'b1;
          end
        end
        LDUSE: begin
          ifid_hold   = 1'b1;
          idex_bubble = 1'b1;
          rem_next    = rem_reg - REM_W'(1);
          if (rem_reg == REM_W'(1)) state_next = RUN;
        end
        FLUSH: begin
          pc_write    = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (branch_taken) begin
            rem_next = FL_RELOAD;
          end else begin
            rem_next = rem_reg - REM_W'(1);
            if (rem_reg == REM_W'(1)) state_next = RUN;
          end
        end
        default: state_next = RUN;
      endcase
    end
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_hold   = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      pipe_freeze = 1'b0;
    end
  end

  always_comb begin
    wtmr_next = '0;
    if (mem_wait) wtmr_next = (wtmr_reg == TMR_MAX) ? wtmr_reg : wtmr_reg + TMR_W'(1);
  end

  // Pulse only on the wait cycle that carries the timer onto its ceiling.
  assign mem_timeout = rst_n && mem_wait && (wtmr_reg == TMR_W'(MEM_TIMEOUT - 1));

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg, wait_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
      wait_cnt_reg  <= '0;
    end else begin
      if (ifid_hold && !pipe_freeze && (stall_cnt_reg != '1)) stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      if (ifid_flush && (flush_cnt_reg != '1))                flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
      if (pipe_freeze && (wait_cnt_reg != '1))                wait_cnt_reg  <= wait_cnt_reg + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
  assign wait_cnt  = wait_cnt_reg;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
  assign wait_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized self-checking bench for pipe_hazard_ctrl with a cycle-level behavioural model.
// Covers directed load-use, branch flush, forwarding, wait timeout and mid-stall reset scenarios.
module tb_pipe_hazard_ctrl;
  localparam int LS = 3;
  localparam int FL = 2;
  localparam int MT = 16;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_regadd, mem_regadd, wb_regadd;
  logic id_uses_rt, ex_memread, mem_regwrite, wb_regwrite, branch_taken, dmem_req, dmem_ready;
  logic pc_write, ifid_hold, ifid_flush, idex_bubble, pipe_freeze, mem_timeout;
  logic [1:0] fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt, flush_cnt, wait_cnt;

  int total = 0;
  int bad = 0;
  bit done = 1'b0;

  // model state: remaining extra stall/flush cycles, consecutive wait length, counters
  int m_stall = 0, m_flush = 0, m_wrun = 0;
  int c_stall = 0, c_flush = 0, c_wait = 0;

  pipe_hazard_ctrl #(.LOAD_STALL_CYC(LS), .FLUSH_CYC(FL), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_memread(ex_memread), .ex_regadd(ex_regadd),
    .mem_regwrite(mem_regwrite), .mem_regadd(mem_regadd),
    .wb_regwrite(wb_regwrite), .wb_regadd(wb_regadd),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .pipe_freeze(pipe_freeze),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int fwd_model(input logic [4:0] src);
    if (mem_regwrite && mem_regadd != 0 && mem_regadd == src) return 2;
    if (wb_regwrite && wb_regadd != 0 && wb_regadd == src) return 1;
    return 0;
  endfunction

  task automatic model_cycle();
    int e_pc, e_hold, e_flush, e_bub, e_frz, e_to, e_fa, e_fb;
    bit w, lu;
    int cmax;
    cmax = (1 << CW) - 1;
    e_pc = 0; e_hold = 0; e_flush = 0; e_bub = 0; e_frz = 0; e_to = 0;
    e_fa = fwd_model(ex_rs);
    e_fb = fwd_model(ex_rt);
    if (!rst_n) begin
      e_flush = 1; e_bub = 1; e_fa = 0; e_fb = 0;
      m_stall = 0; m_flush = 0; m_wrun = 0;
      c_stall = 0; c_flush = 0; c_wait = 0;
    end else begin
      w  = dmem_req && !dmem_ready;
      lu = ex_memread && ex_regadd != 0 &&
           (ex_regadd == id_rs || (id_uses_rt && ex_regadd == id_rt));
      if (w) begin
        e_frz = 1; e_hold = 1;
        if (m_wrun < MT) begin
          m_wrun++;
          if (m_wrun == MT) e_to = 1;
        end
      end else begin
        m_wrun = 0;
        if (m_stall > 0) begin
          e_hold = 1; e_bub = 1; m_stall--;
        end else if (m_flush > 0) begin
          e_pc = 1; e_flush = 1; e_bub = 1;
          m_flush = branch_taken ? FL - 1 : m_flush - 1;
        end else if (branch_taken) begin
          e_pc = 1; e_flush = 1; e_bub = 1; m_flush = FL - 1;
        end else if (lu) begin
          e_hold = 1; e_bub = 1; m_stall = LS - 1;
        end else begin
          e_pc = 1;
        end
      end
    end
    check("pc_write", pc_write, e_pc);
    check("ifid_hold", ifid_hold, e_hold);
    check("ifid_flush", ifid_flush, e_flush);
    check("idex_bubble", idex_bubble, e_bub);
    check("pipe_freeze", pipe_freeze, e_frz);
    check("mem_timeout", mem_timeout, e_to);
    check("fwd_a", fwd_a, e_fa);
    check("fwd_b", fwd_b, e_fb);
`ifdef HAZ_PERF_CNT_EN
    check("stall_cnt", stall_cnt, c_stall);
    check("flush_cnt", flush_cnt, c_flush);
    check("wait_cnt", wait_cnt, c_wait);
    if (rst_n) begin
      if (e_hold && !e_frz && c_stall < cmax) c_stall++;
      if (e_flush && c_flush < cmax) c_flush++;
      if (e_frz && c_wait < cmax) c_wait++;
    end
`else
    check("stall_cnt", stall_cnt, 0);
    check("flush_cnt", flush_cnt, 0);
    check("wait_cnt", wait_cnt, 0);
`endif
  endtask

  initial begin
    while (!done) begin
      @(negedge clk);
      if (!done) model_cycle();
    end
  end

  task automatic idle();
    id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_rs = 0; ex_rt = 0;
    ex_memread = 0; ex_regadd = 0; mem_regwrite = 0; mem_regadd = 0;
    wb_regwrite = 0; wb_regadd = 0; branch_taken = 0; dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_use();
    ex_memread = 1; ex_regadd = 5; id_rs = 5;
  endtask

  initial begin
    int pulses, pcyc;
    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_pc_write", pc_write, 0);
    check("rst_ifid_flush", ifid_flush, 1);
    check("rst_idex_bubble", idex_bubble, 1);
    check("rst_pipe_freeze", pipe_freeze, 0);
    tick(); rst_n = 1;

    // forwarding priority
    tick(); ex_rs = 7; ex_rt = 7; mem_regadd = 7; wb_regadd = 7; mem_regwrite = 1; wb_regwrite = 1;
    #1 check("fwd_mem_wins", fwd_a, 2); check("fwd_b_mem", fwd_b, 2);
    tick(); mem_regwrite = 0;
    #1 check("fwd_wb", fwd_a, 1);
    tick(); idle(); wb_regwrite = 1; wb_regadd = 0;
    #1 check("fwd_r0", fwd_a, 0);

    // load-use with 3 stall cycles
    tick(); idle(); set_load_use();
    #1 check("lu_pc0", pc_write, 0); check("lu_hold", ifid_hold, 1); check("lu_bub", idex_bubble, 1);
    tick(); idle();
    #1 check("lu_pc1", pc_write, 0);
    tick();
    #1 check("lu_pc2", pc_write, 0);
    tick();
    #1 check("lu_resume", pc_write, 1);
    tick(); ex_memread = 1; ex_regadd = 0; id_rs = 0;
    #1 check("lu_r0_pc", pc_write, 1); check("lu_r0_hold", ifid_hold, 0);

    // branch flush for 2 cycles
    tick(); idle(); branch_taken = 1;
    #1 check("br_flush0", ifid_flush, 1); check("br_pc0", pc_write, 1);
    tick(); idle();
    #1 check("br_flush1", ifid_flush, 1); check("br_pc1", pc_write, 1);
    tick();
    #1 check("br_done", ifid_flush, 0);

    // 20-cycle memory wait with a load-use pending
    tick(); idle(); set_load_use(); dmem_req = 1; dmem_ready = 0;
    pulses = 0; pcyc = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i > 1) tick();
      #1 check("wait_freeze", pipe_freeze, 1);
      if (mem_timeout) begin pulses++; pcyc = i; end
    end
    check("timeout_pulses", pulses, 1);
    check("timeout_cycle", pcyc, 16);
    tick(); dmem_ready = 1;
    #1 check("post_wait_frz", pipe_freeze, 0); check("post_wait_hold", ifid_hold, 1);
    tick(); idle();
    tick();
    tick();

    // reset in the middle of a multi-cycle stall
    set_load_use();
    tick(); idle(); rst_n = 0;
    #1 check("midrst_flush", ifid_flush, 1); check("midrst_pc", pc_write, 0);
    check("midrst_stallcnt", stall_cnt, 0);
    tick(); rst_n = 1;
    #1 check("midrst_run_pc", pc_write, 1); check("midrst_run_hold", ifid_hold, 0);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      tick();
      rst_n = ($urandom_range(0, 299) != 0);
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      id_uses_rt = 1'($urandom_range(0, 1));
      ex_rs = 5'($urandom_range(0, 3)); ex_rt = 5'($urandom_range(0, 3));
      ex_memread = ($urandom_range(0, 2) == 0);
      ex_regadd = 5'($urandom_range(0, 3));
      mem_regwrite = 1'($urandom_range(0, 1)); mem_regadd = 5'($urandom_range(0, 3));
      wb_regwrite = 1'($urandom_range(0, 1)); wb_regadd = 5'($urandom_range(0, 3));
      branch_taken = ($urandom_range(0, 5) == 0);
      if ((n / 200) % 4 == 3) begin
        dmem_req = 1; dmem_ready = ($urandom_range(0, 24) == 0);
      end else begin
        dmem_req = 1'($urandom_range(0, 1)); dmem_ready = 1'($urandom_range(0, 1));
      end
    end
    tick(); rst_n = 1; idle();
    @(negedge clk);
    done = 1;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
